// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with a valid/ready holding register and overrun flag.
// Define SIPO_PARITY_EN to add a trailing even-parity bit to each frame and report par_err.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    bit_cnt,
  output logic             busy,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             overrun,
  output logic             par_err
);

`ifdef SIPO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  typedef enum logic {S_DATA = 1'b0, S_PAR = 1'b1} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] q_r;
  logic [CW-1:0]    bit_cnt_r;
  logic             busy_r;
  logic [WIDTH-1:0] pout_r;
  logic             pout_valid_r;
  logic             overrun_r;
  logic             par_err_r;

  logic [WIDTH-1:0] shift_s;
  logic [WIDTH-1:0] word_s;
  logic             done_s;
  logic             perr_s;

  function automatic logic parity_f(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Shift-register contents after sampling sin in the configured bit order.
  always_comb begin
    if (MSB_FIRST) begin
      shift_s = {q_r[WIDTH-2:0], sin};
    end else begin
      shift_s = {sin, q_r[WIDTH-1:1]};
    end
  end

  // Frame-completion detect and the word/parity result it delivers.
  always_comb begin
    done_s = 1'b0;
    word_s = shift_s;
    perr_s = 1'b0;
    if (!clear && sin_valid) begin
      if (state_r == S_PAR) begin
        // The parity bit never enters q, so the word is the current q.
        done_s = 1'b1;
        word_s = q_r;
        perr_s = parity_f(q_r) ^ sin;
      end else if (bit_cnt_r == LAST_CNT && !PAR_EN) begin
        done_s = 1'b1;
      end else begin
        done_s = 1'b0;
      end
    end else begin
      done_s = 1'b0;
    end
  end

  // Frame FSM: shift register, bit counter and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_DATA;
      q_r       <= '0;
      bit_cnt_r <= '0;
      busy_r    <= 1'b0;
    end else if (clear) begin
      state_r   <= S_DATA;
      q_r       <= '0;
      bit_cnt_r <= '0;
      busy_r    <= 1'b0;
    end else if (sin_valid) begin
      case (state_r)
        S_DATA: begin
          q_r <= shift_s;
          if (bit_cnt_r == LAST_CNT) begin
            if (PAR_EN) begin
              state_r   <= S_PAR;
              bit_cnt_r <= FULL_CNT;
              busy_r    <= 1'b1;
            end else begin
              bit_cnt_r <= '0;
              busy_r    <= 1'b0;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CW'(1);
            busy_r    <= 1'b1;
          end
        end
        S_PAR: begin
          state_r   <= S_DATA;
          bit_cnt_r <= '0;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r   <= S_DATA;
          bit_cnt_r <= '0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: load on completion if free or being popped, else flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      pout_r       <= '0;
      pout_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
      par_err_r    <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (done_s) begin
        if (!pout_valid_r || pout_ready) begin
          pout_r       <= word_s;
          pout_valid_r <= 1'b1;
          par_err_r    <= perr_s;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (pout_valid_r && pout_ready) begin
        pout_valid_r <= 1'b0;
      end
    end
  end

  assign q          = q_r;
  assign bit_cnt    = bit_cnt_r;
  assign busy       = busy_r;
  assign pout       = pout_r;
  assign pout_valid = pout_valid_r;
  assign overrun    = overrun_r;
  assign par_err    = PAR_EN ? par_err_r : 1'b0;

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench: an MSB-first and an LSB-first deserialiser share one serial stream.
module tb_sipo_deser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b0;
  logic sin_valid = 1'b0;
  logic clear = 1'b0;
  logic pout_ready = 1'b0;

  logic [7:0] q_m, q_l, pout_m, pout_l;
  logic [3:0] bit_cnt_m, bit_cnt_l;
  logic busy_m, busy_l, pout_valid_m, pout_valid_l;
  logic overrun_m, overrun_l, par_err_m, par_err_l;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ovr   = 0;

  // reference model state
  logic [7:0] m_qm = 8'h00, m_ql = 8'h00;
  int   m_cnt   = 0;
  logic m_inpar = 1'b0;
  logic m_valid = 1'b0;
  logic [7:0] sb_m[$];
  logic [7:0] sb_l[$];
  logic       sb_p[$];

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .q(q_m), .bit_cnt(bit_cnt_m), .busy(busy_m), .pout(pout_m), .pout_valid(pout_valid_m),
    .pout_ready(pout_ready), .overrun(overrun_m), .par_err(par_err_m));

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .q(q_l), .bit_cnt(bit_cnt_l), .busy(busy_l), .pout(pout_l), .pout_valid(pout_valid_l),
    .pout_ready(pout_ready), .overrun(overrun_l), .par_err(par_err_l));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; sin_valid = 1'b0; clear = 1'b0;
      @(posedge clk);
    end
    #1;
    m_qm = 8'h00; m_ql = 8'h00; m_cnt = 0; m_inpar = 1'b0; m_valid = 1'b0;
    sb_m.delete(); sb_l.delete(); sb_p.delete();
    check_eq("rst_q_m", q_m, 32'h0);          check_eq("rst_q_l", q_l, 32'h0);
    check_eq("rst_cnt_m", bit_cnt_m, 32'h0);  check_eq("rst_cnt_l", bit_cnt_l, 32'h0);
    check_eq("rst_pout_m", pout_m, 32'h0);    check_eq("rst_pout_l", pout_l, 32'h0);
    check_eq("rst_valid_m", pout_valid_m, 32'h0);
    check_eq("rst_ovr_m", overrun_m, 32'h0);  check_eq("rst_perr_m", par_err_m, 32'h0);
  endtask

  task automatic step(input logic b, input logic v, input logic c, input logic rdy);
    logic done, perr, exp_ovr, e;
    logic [7:0] wm, wl;
    done = 1'b0; perr = 1'b0; exp_ovr = 1'b0; wm = 8'h00; wl = 8'h00;
    @(negedge clk);
    rst = 1'b0; sin = b; sin_valid = v; clear = c; pout_ready = rdy;
    // consumer side: a handshake this edge pops the scoreboard
    if (m_valid && rdy) begin
      check_eq("sb_nonempty", (sb_m.size() != 0), 32'h1);
      if (sb_m.size() != 0) begin
        check_eq("pop_pout_m", pout_m, sb_m.pop_front());
        check_eq("pop_pout_l", pout_l, sb_l.pop_front());
        e = sb_p.pop_front();
        check_eq("pop_perr_m", par_err_m, e);
        check_eq("pop_perr_l", par_err_l, e);
      end
    end
    if (c) begin
      m_qm = 8'h00; m_ql = 8'h00; m_cnt = 0; m_inpar = 1'b0;
    end else if (v) begin
      if (m_inpar) begin
        done = 1'b1; wm = m_qm; wl = m_ql; perr = (^m_qm) ^ b;
        m_cnt = 0; m_inpar = 1'b0;
      end else begin
        m_qm = {m_qm[6:0], b};
        m_ql = {b, m_ql[7:1]};
        m_cnt++;
        if (m_cnt == 8) begin
`ifdef SIPO_PARITY_EN
          m_inpar = 1'b1;
`else
          done = 1'b1; wm = m_qm; wl = m_ql; m_cnt = 0;
`endif
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        sb_m.push_back(wm); sb_l.push_back(wl); sb_p.push_back(perr);
        m_valid = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    n_ovr += int'(overrun_m);
    check_eq("q_m", q_m, m_qm);                 check_eq("q_l", q_l, m_ql);
    check_eq("cnt_m", bit_cnt_m, m_cnt);        check_eq("cnt_l", bit_cnt_l, m_cnt);
    check_eq("busy_m", busy_m, (m_cnt != 0));   check_eq("busy_l", busy_l, (m_cnt != 0));
    check_eq("ovr_m", overrun_m, exp_ovr);      check_eq("ovr_l", overrun_l, exp_ovr);
    check_eq("valid_m", pout_valid_m, m_valid); check_eq("valid_l", pout_valid_l, m_valid);
  endtask

  // Sends byte w starting at w[7]; rdy_last applies to the edge that completes the frame.
  task automatic send_frame(input logic [7:0] w, input logic rdy, input logic rdy_last,
                            input int maxgap, input logic pflip);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      repeat ($urandom_range(0, maxgap)) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, rdy);
`ifdef SIPO_PARITY_EN
      r = rdy;
`else
      r = (i == 0) ? rdy_last : rdy;
`endif
      step(w[i], 1'b1, 1'b0, r);
    end
`ifdef SIPO_PARITY_EN
    repeat ($urandom_range(0, maxgap)) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, rdy);
    step((^w) ^ pflip, 1'b1, 1'b0, rdy_last);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr0;
    // T1: reset, then reset mid-frame, then a clean word
    do_reset(2);
    step(1'b1, 1'b1, 1'b0, 1'b1); step(1'b0, 1'b1, 1'b0, 1'b1); step(1'b1, 1'b1, 1'b0, 1'b1);
    do_reset(2);
    send_frame(8'h1E, 1'b1, 1'b1, 0, 1'b0);
    check_eq("t1_pout_m", pout_m, 32'h1E); check_eq("t1_pout_l", pout_l, 32'h78);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // T2: bits 1,1,0,0,1,0,1,0 back to back
    send_frame(8'hCA, 1'b1, 1'b1, 0, 1'b0);
    check_eq("t2_pout_m", pout_m, 32'hCA); check_eq("t2_pout_l", pout_l, 32'h53);
    check_eq("t2_valid", pout_valid_m, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t2_valid_fall", pout_valid_m, 32'h0);

    // T3: same bits with random gaps
    send_frame(8'hCA, 1'b1, 1'b1, 3, 1'b0);
    check_eq("t3_pout_m", pout_m, 32'hCA); check_eq("t3_pout_l", pout_l, 32'h53);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // T4: backpressure, overrun, then pop
    ovr0 = n_ovr;
    send_frame(8'h11, 1'b0, 1'b0, 1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1, 1'b0);
    check_eq("t4_hold_m", pout_m, 32'h11);
    check_eq("t4_ovr_count", n_ovr - ovr0, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t4_pop_valid", pout_valid_m, 32'h0);
    // completion on the same edge as a pop
    ovr0 = n_ovr;
    send_frame(8'h33, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b1, 0, 1'b0);
    check_eq("t4_swap_pout", pout_m, 32'h44);
    check_eq("t4_swap_valid", pout_valid_m, 32'h1);
    check_eq("t4_swap_ovr", n_ovr - ovr0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // T5: clear wins over sin_valid
    step(1'b1, 1'b1, 1'b0, 1'b1); step(1'b1, 1'b1, 1'b0, 1'b1); step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("t5_cnt", bit_cnt_m, 32'h0); check_eq("t5_q", q_m, 32'h0);
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    check_eq("t5_pout_m", pout_m, 32'hA5); check_eq("t5_pout_l", pout_l, 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // T6: parity
`ifdef SIPO_PARITY_EN
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    check_eq("t6_perr0", par_err_m, 32'h0);
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b1);
    check_eq("t6_perr1", par_err_m, 32'h1);
    check_eq("t6_perr1_l", par_err_l, 32'h1);
`else
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("t6_ninth_cnt", bit_cnt_m, 32'h1);
    check_eq("t6_ninth_busy", busy_m, 32'h1);
    check_eq("t6_perr_tied", par_err_m, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
`endif

    // random frames with random backpressure and gaps
    for (int k = 0; k < 20; k++) begin
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("sb_drained", sb_m.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
